// File: rtl/ifetch_buffer.sv
// Fetch stage: issues the PC over a req/gnt + rvalid handshake and queues returned
// instructions for decode. Define IFETCH_PERF_EN to add fetch/stall/flush counters.
module ifetch_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    input  logic              instr_ready_i
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_stall_o,
    output logic [31:0]       perf_flush_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] L_DEPTH = DEPTH[CNT_W:0];

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_out_cnt;
    logic [CNT_W-1:0]    r_buf_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;
    logic [PTR_W-1:0]    r_pcq_wr;
    logic [PTR_W-1:0]    r_pcq_rd;
    logic [PTR_W-1:0]    r_buf_wr;
    logic [PTR_W-1:0]    r_buf_rd;
    logic [ADDR_W-1:0]   r_pcq     [DEPTH];
    logic [DATA_W-1:0]   r_buf_ins [DEPTH];
    logic [ADDR_W-1:0]   r_buf_pc  [DEPTH];

    logic                w_credit;
    logic                w_req;
    logic                w_grant;
    logic                w_rsp;
    logic                w_rsp_keep;
    logic                w_pop;
    logic [CNT_W-1:0]    w_drop_next;

    // Credit counts only registered occupancy, so a same-cycle pop never frees a slot early.
    assign w_credit    = (({1'b0, r_out_cnt} + {1'b0, r_buf_cnt}) < L_DEPTH);
    assign w_req       = !rst_i && (r_state == ST_RUN) && w_credit && !flush_i;
    assign w_grant     = w_req && imem_gnt_i;
    assign w_rsp       = imem_rvalid_i && (r_out_cnt != CNT_W'(0));
    assign w_rsp_keep  = w_rsp && (r_state == ST_RUN) && !flush_i;
    assign w_pop       = instr_valid_o && instr_ready_i;
    assign w_drop_next = r_out_cnt - CNT_W'(w_rsp);

    assign imem_req_o    = w_req;
    assign imem_addr_o   = pc_i;
    assign stall_o       = rst_i || (!flush_i && !w_grant);
    assign instr_valid_o = (r_buf_cnt != CNT_W'(0));
    assign instr_o       = instr_valid_o ? r_buf_ins[r_buf_rd] : {DATA_W{1'b0}};
    assign instr_pc_o    = instr_valid_o ? r_buf_pc[r_buf_rd]  : {ADDR_W{1'b0}};

    // Control FSM, counters and pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_out_cnt  <= CNT_W'(0);
            r_buf_cnt  <= CNT_W'(0);
            r_drop_cnt <= CNT_W'(0);
            r_pcq_wr   <= PTR_W'(0);
            r_pcq_rd   <= PTR_W'(0);
            r_buf_wr   <= PTR_W'(0);
            r_buf_rd   <= PTR_W'(0);
        end else if (flush_i) begin
            r_buf_cnt  <= CNT_W'(0);
            r_buf_wr   <= PTR_W'(0);
            r_buf_rd   <= PTR_W'(0);
            r_pcq_wr   <= PTR_W'(0);
            r_pcq_rd   <= PTR_W'(0);
            r_drop_cnt <= w_drop_next;
            r_out_cnt  <= w_drop_next;
            r_state    <= (w_drop_next != CNT_W'(0)) ? ST_DRAIN : ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_out_cnt <= r_out_cnt + CNT_W'(w_grant) - CNT_W'(w_rsp_keep);
                    r_pcq_wr  <= r_pcq_wr + PTR_W'(w_grant);
                    r_pcq_rd  <= r_pcq_rd + PTR_W'(w_rsp_keep);
                    r_buf_cnt <= r_buf_cnt + CNT_W'(w_rsp_keep) - CNT_W'(w_pop);
                    r_buf_wr  <= r_buf_wr + PTR_W'(w_rsp_keep);
                    r_buf_rd  <= r_buf_rd + PTR_W'(w_pop);
                end
                ST_DRAIN: begin
                    if (w_rsp) begin
                        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                        r_out_cnt  <= r_out_cnt - CNT_W'(1);
                        r_state    <= (r_drop_cnt == CNT_W'(1)) ? ST_RUN : ST_DRAIN;
                    end else begin
                        r_state    <= ST_DRAIN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Payload storage; contents are only observed through valid occupancy.
    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_pcq[r_pcq_wr] <= pc_i;
        end
        if (w_rsp_keep) begin
            r_buf_ins[r_buf_wr] <= imem_rdata_i;
            r_buf_pc[r_buf_wr]  <= r_pcq[r_pcq_rd];
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_fetch <= 32'd0;
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            r_perf_fetch <= r_perf_fetch + 32'(w_pop);
            r_perf_stall <= r_perf_stall + 32'(stall_o);
            r_perf_flush <= r_perf_flush + 32'(flush_i);
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_stall_o = r_perf_stall;
    assign perf_flush_o = r_perf_flush;
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomized scoreboard bench for ifetch_buffer: a queue-based reference model
// predicts every delivered instruction and the per-cycle handshake outputs.
module tb_ifetch_buffer;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [ADDR_W-1:0] pc_i = '0;
    logic              flush_i = 1'b0;
    logic              stall_o;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_gnt_i = 1'b0;
    logic              imem_rvalid_i = 1'b0;
    logic [DATA_W-1:0] imem_rdata_i = '0;
    logic              instr_valid_o;
    logic [DATA_W-1:0] instr_o;
    logic [ADDR_W-1:0] instr_pc_o;
    logic              instr_ready_i = 1'b0;
`ifdef IFETCH_PERF_EN
    logic [31:0]       perf_fetch_o;
    logic [31:0]       perf_stall_o;
    logic [31:0]       perf_flush_o;
`endif

    ifetch_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .flush_i(flush_i), .stall_o(stall_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_o(perf_fetch_o), .perf_stall_o(perf_stall_o), .perf_flush_o(perf_flush_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model state: PCs in flight, buffered {instr,pc}, responses to discard.
    logic [31:0] m_pend[$];
    logic [63:0] m_buf[$];
    int          m_drop = 0;
    // Memory model: granted addresses with the earliest cycle they may return.
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    // Scoreboard of deliveries the decode stage should see, in order.
    logic [63:0] exp_q[$];

    logic [31:0] m_pc = 32'h0;
    logic [31:0] next_target = 32'h0;
    int          cyc = 0;
    bit          started = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_stall = 1'b1;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    int          dut_gnt_cnt = 0;
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_stall = 32'h0;
    logic [31:0] m_flush = 32'h0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // One clock cycle: drive inputs after the edge and advance the reference model.
    task automatic step(input logic f, input logic g, input logic rv_en, input logic rdy);
        logic        rsp;
        logic        req;
        logic        grant;
        logic        pop;
        logic [31:0] rd;
        @(posedge clk_i);
        #1;
        cyc++;
        rsp = rv_en && (mem_addr_q.size() != 0) && (mem_due_q[0] <= cyc);
        rd  = rsp ? mdata(mem_addr_q[0]) : $urandom();
        rst_i = 1'b0;
        pc_i = m_pc;
        flush_i = f;
        imem_gnt_i = g;
        imem_rvalid_i = rsp;
        imem_rdata_i = rd;
        instr_ready_i = rdy;

        req   = (m_drop == 0) && ((m_pend.size() + m_buf.size()) < DEPTH) && !f;
        grant = req && g;
        exp_req   = req;
        exp_stall = !f && !grant;
        exp_valid = (m_buf.size() != 0);
        exp_addr  = m_pc;
        started   = 1'b1;
        pop = exp_valid && rdy;
        m_stall += 32'(exp_stall);
        m_flush += 32'(f);
        m_fetch += 32'(pop);

        if (pop) exp_q.push_back(m_buf.pop_front());
        if (rsp) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (grant) begin
            mem_addr_q.push_back(m_pc);
            mem_due_q.push_back(cyc + 1);
        end
        if (f) begin
            m_buf.delete();
            m_drop = m_drop + m_pend.size() - (rsp ? 1 : 0);
            m_pend.delete();
        end else if (rsp) begin
            if (m_drop > 0) m_drop--;
            else m_buf.push_back({rd, m_pend.pop_front()});
        end
        if (grant) m_pend.push_back(m_pc);

        if (f) m_pc = next_target;
        else if (grant) m_pc = m_pc + 32'd4;
    endtask

    task automatic sync();
        @(negedge clk_i);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_pend.size() + m_buf.size() + m_drop) != 0 && n < 64) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            n++;
        end
        chk("drain_bound", 64'(n < 64), 64'd1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, 64'(instr_valid_o), 64'd0);
        chk({tag, "_instr"}, 64'(instr_o), 64'd0);
        chk({tag, "_instr_pc"}, 64'(instr_pc_o), 64'd0);
        chk({tag, "_req"}, 64'(imem_req_o), 64'd0);
        chk({tag, "_stall"}, 64'(stall_o), 64'd1);
    endtask

    task automatic reset_model();
        m_buf.delete();
        m_pend.delete();
        m_drop = 0;
        mem_addr_q.delete();
        mem_due_q.delete();
        exp_q.delete();
        m_fetch = 32'h0;
        m_stall = 32'h0;
        m_flush = 32'h0;
    endtask

    // Monitor: compares handshake outputs every cycle and each delivered instruction.
    always @(negedge clk_i) begin
        logic [63:0] e;
        if (!rst_i && started) begin
            chk("imem_req", 64'(imem_req_o), 64'(exp_req));
            chk("stall", 64'(stall_o), 64'(exp_stall));
            chk("instr_valid", 64'(instr_valid_o), 64'(exp_valid));
            chk("imem_addr", 64'(imem_addr_o), 64'(exp_addr));
            if (imem_req_o && imem_gnt_i) dut_gnt_cnt++;
            if (instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery: got pc %0h, expected nothing", instr_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", 64'(instr_o), 64'(e[63:32]));
                    chk("instr_pc", 64'(instr_pc_o), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2;
        reset_checks("reset_early");
        repeat (3) @(posedge clk_i);
        #1;
        reset_checks("reset_held");

        // Steady stream from PC 0.
        repeat (20) step(1'b0, 1'b1, 1'b1, 1'b1);
        drain();

        // Decode blocked: exactly DEPTH grants, then one more per pop.
        sync();
        dut_gnt_cnt = 0;
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0);
        sync();
        chk("grants_full", 64'(dut_gnt_cnt), 64'd4);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0);
        sync();
        chk("grants_after_pop", 64'(dut_gnt_cnt), 64'd5);
        drain();

        // Grant withheld while PC is 0x20.
        next_target = 32'h20;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
        sync();
        chk("hold_addr", 64'(imem_addr_o), 64'h20);
        chk("hold_stall", 64'(stall_o), 64'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // Flush with two requests in flight.
        next_target = 32'h10;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        next_target = 32'h100;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b1);
        drain();

        // Flush coincident with the only outstanding response.
        next_target = 32'h200;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        next_target = 32'h300;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b1);
        drain();

        // Asynchronous reset with three buffered instructions.
        for (int i = 0; i < 20 && m_buf.size() < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("prefill_three", 64'(m_buf.size()), 64'd3);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        reset_checks("reset_mid");
        reset_model();
        repeat (2) @(posedge clk_i);

        // Randomized traffic.
        repeat (1500) begin
            next_target = 32'($urandom_range(0, 16'h3FFF)) << 2;
            step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6));
        end
        drain();
        @(posedge clk_i);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
`ifdef IFETCH_PERF_EN
        chk("perf_fetch", 64'(perf_fetch_o), 64'(m_fetch));
        chk("perf_stall", 64'(perf_stall_o), 64'(m_stall));
        chk("perf_flush", 64'(perf_flush_o), 64'(m_flush));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
